// File: rtl/cic_interpolator.sv
// -----------------------------------------------------------------------------
// cic_interpolator
//
// Five-stage CIC interpolator with a differential delay of one. Samples arrive
// at the low rate through a valid/ready port. A comb section runs once per
// input period. The comb result is then zero-stuffed by R. Five integrators run
// on every clk, and an arithmetic shift/truncate stage produces one output
// sample per clk for the transmit/DAC path.
//
// Ports
//   clk        clock, single domain
//   rst_n      asynchronous active-low reset
//   gain       output scaling; shift = REGISTER_WIDTH-DATA_WIDTH-gain (0 if gain too large)
//   data_in    signed input sample
//   in_valid   data_in is valid
//   in_ready   block can accept data_in this cycle
//   data_out   signed output sample, registered, one per clk
//   out_valid  data_out carries filtered data (after the pipeline has filled)
//   underrun   sticky flag: a load slot found no sample after the block was primed
// -----------------------------------------------------------------------------
module cic_interpolator #(
    parameter int DATA_WIDTH          = 12,
    parameter int REGISTER_WIDTH      = 64,
    parameter int INTERPOLATION_RATIO = 16,
    parameter int GAIN_WIDTH          = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [GAIN_WIDTH-1:0]        gain,
    input  logic signed [DATA_WIDTH-1:0] data_in,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic signed [DATA_WIDTH-1:0] data_out,
    output logic                         out_valid,
    output logic                         underrun
);

    localparam int NUM_STAGES = 5;
    localparam int CW         = $clog2(INTERPOLATION_RATIO);
    localparam int MAX_SHIFT  = REGISTER_WIDTH - DATA_WIDTH;
    localparam int SW         = $clog2(MAX_SHIFT + 1);
    // Load edge to the first data_out edge: 5 comb + 1 stuff + 5 integ + 1 out.
    localparam int LATENCY    = 12;
    localparam int WW         = $clog2(LATENCY);

    localparam logic [CW-1:0] LAST_COUNT  = CW'(INTERPOLATION_RATIO - 1);
    localparam logic [CW-1:0] STUFF_COUNT = CW'(NUM_STAGES + 1);

    // ------------------------------------------------------------------
    // Phase counter: free-running, never stalls
    // ------------------------------------------------------------------
    logic [CW-1:0] count_reg;
    logic          load_slot;
    logic          accept;

    assign load_slot = (count_reg == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (count_reg == LAST_COUNT) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_reg + CW'(1);
        end
    end

    // ------------------------------------------------------------------
    // Input holding register and load slot
    // ------------------------------------------------------------------
    logic signed [DATA_WIDTH-1:0]     hold_reg;
    logic                             hold_full_reg;
    logic                             primed_reg;
    logic                             underrun_reg;
    logic signed [REGISTER_WIDTH-1:0] x_reg;

    // The hold slot always frees up on the load edge. This lets a new sample
    // be accepted on that same edge while the old sample moves into the comb.
    assign in_ready = !hold_full_reg || load_slot;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_reg      <= '0;
            hold_full_reg <= 1'b0;
        end else begin
            if (accept) begin
                hold_reg <= data_in;
            end
            if (accept) begin
                hold_full_reg <= 1'b1;
            end else if (load_slot) begin
                hold_full_reg <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_reg        <= '0;
            primed_reg   <= 1'b0;
            underrun_reg <= 1'b0;
        end else if (load_slot) begin
            if (hold_full_reg) begin
                x_reg      <= {{(REGISTER_WIDTH-DATA_WIDTH){hold_reg[DATA_WIDTH-1]}}, hold_reg};
                primed_reg <= 1'b1;
            end else begin
                // An empty slot feeds a zero. It is only an error once real
                // data has started flowing.
                x_reg <= '0;
                if (primed_reg) begin
                    underrun_reg <= 1'b1;
                end
            end
        end
    end

    assign underrun = underrun_reg;

    // ------------------------------------------------------------------
    // Comb section: stage k fires on the edge where count == k
    // ------------------------------------------------------------------
    genvar gi;
    for (gi = 1; gi <= NUM_STAGES; gi++) begin : g_comb
        logic signed [REGISTER_WIDTH-1:0] c_in;
        logic signed [REGISTER_WIDTH-1:0] c_reg;
        logic signed [REGISTER_WIDTH-1:0] d_reg;

        if (gi == 1) begin : g_src
            assign c_in = x_reg;
        end else begin : g_src
            assign c_in = g_comb[gi-1].c_reg;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                c_reg <= '0;
                d_reg <= '0;
            end else if (count_reg == CW'(gi)) begin
                c_reg <= c_in - d_reg;
                d_reg <= c_in;
            end
        end
    end

    logic signed [REGISTER_WIDTH-1:0] comb_out;
    assign comb_out = g_comb[NUM_STAGES].c_reg;

    // ------------------------------------------------------------------
    // Zero-stuff: the comb result is presented for exactly one clk per period
    // ------------------------------------------------------------------
    logic signed [REGISTER_WIDTH-1:0] up_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            up_reg <= '0;
        end else if (count_reg == STUFF_COUNT) begin
            up_reg <= comb_out;
        end else begin
            up_reg <= '0;
        end
    end

    // ------------------------------------------------------------------
    // Integrators, every clk. Overflow wraps by design; the comb
    // differences cancel the wrap in the final result.
    // ------------------------------------------------------------------
    for (gi = 1; gi <= NUM_STAGES; gi++) begin : g_integ
        logic signed [REGISTER_WIDTH-1:0] i_in;
        logic signed [REGISTER_WIDTH-1:0] i_reg;

        if (gi == 1) begin : g_src
            assign i_in = up_reg;
        end else begin : g_src
            assign i_in = g_integ[gi-1].i_reg;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                i_reg <= '0;
            end else begin
                i_reg <= i_reg + i_in;
            end
        end
    end

    logic signed [REGISTER_WIDTH-1:0] integ_out;
    assign integ_out = g_integ[NUM_STAGES].i_reg;

    // ------------------------------------------------------------------
    // Output scaling: arithmetic shift, then keep the low bits (no saturation)
    // ------------------------------------------------------------------
    logic [31:0]                  gain_ext;
    logic [SW-1:0]                shift_amt;
    logic signed [DATA_WIDTH-1:0] data_out_next;
    logic signed [DATA_WIDTH-1:0] data_out_reg;

    assign gain_ext = 32'(gain);

    always_comb begin
        shift_amt = '0;
        if (gain_ext <= 32'(MAX_SHIFT)) begin
            shift_amt = SW'(32'(MAX_SHIFT) - gain_ext);
        end
    end

    assign data_out_next = DATA_WIDTH'(integ_out >>> shift_amt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out_reg <= '0;
        end else begin
            data_out_reg <= data_out_next;
        end
    end

    assign data_out = data_out_reg;

    // ------------------------------------------------------------------
    // out_valid rises LATENCY edges after the priming load, then stays high
    // ------------------------------------------------------------------
    logic [WW-1:0] warm_cnt_reg;
    logic          out_valid_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            warm_cnt_reg  <= '0;
            out_valid_reg <= 1'b0;
        end else if (primed_reg && !out_valid_reg) begin
            warm_cnt_reg <= warm_cnt_reg + WW'(1);
            if (warm_cnt_reg == WW'(LATENCY - 1)) begin
                out_valid_reg <= 1'b1;
            end
        end
    end

    assign out_valid = out_valid_reg;

endmodule

// File: tb/tb_cic_interpolator.sv
// -----------------------------------------------------------------------------
// tb_cic_interpolator
//
// Directed bench for cic_interpolator (R=16, 12-bit data, 64-bit registers).
// It covers reset values, the impulse response, underrun, mid-stream reset,
// the DC gain and the in_ready pattern. It also drives a ramp through the
// accept/load collision, with the expected output taken from a convolution
// against the closed-form CIC impulse response. It then checks the
// negative full-scale input.
// -----------------------------------------------------------------------------
module tb_cic_interpolator;

    localparam int DW = 12;
    localparam int R  = 16;
    localparam int HL = 5 * (R - 1) + 1;

    logic                 clk;
    logic                 rst_n;
    logic [7:0]           gain;
    logic signed [DW-1:0] data_in;
    logic                 in_valid;
    logic                 in_ready;
    logic signed [DW-1:0] data_out;
    logic                 out_valid;
    logic                 underrun;

    int checks = 0;
    int errors = 0;
    int edge_idx = -1;

    longint h   [0:HL-1];
    longint tmp [0:HL-1];
    longint imp_tab [0:7] = '{1, 5, 15, 35, 70, 126, 210, 330};

    cic_interpolator #(
        .DATA_WIDTH          (DW),
        .REGISTER_WIDTH      (64),
        .INTERPOLATION_RATIO (R),
        .GAIN_WIDTH          (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .gain      (gain),
        .data_in   (data_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_out  (data_out),
        .out_valid (out_valid),
        .underrun  (underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        edge_idx++;
    endtask

    task automatic chk(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Hold reset for two edges, then release between edges. The next edge is edge 0.
    task automatic do_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        data_in  = '0;
        tick();
        tick();
        rst_n    = 1'b1;
        edge_idx = -1;
    endtask

    initial begin
        logic              acc;
        int                load_edge [$];
        longint            load_val  [$];
        longint            pending   [$];
        longint            y;
        logic signed [63:0] y_sh;
        logic signed [DW-1:0] exp12;
        int                n_acc;

        // Reference impulse response: five cascaded length-R boxcars.
        for (int i = 0; i < HL; i++) h[i] = (i == 0) ? 1 : 0;
        for (int s = 0; s < 5; s++) begin
            for (int n = 0; n < HL; n++) begin
                tmp[n] = 0;
                for (int k = 0; k < R; k++)
                    if (n - k >= 0) tmp[n] += h[n - k];
            end
            for (int n = 0; n < HL; n++) h[n] = tmp[n];
        end

        gain = 8'd52;
        rst_n = 1'b0;
        in_valid = 1'b0;
        data_in = '0;
        #2;
        chk("rst_data_out", $signed(data_out), 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_underrun", underrun, 0);
        chk("rst_in_ready", in_ready, 1);
        do_reset();

        // ---------------- Impulse + underrun (shift 0) ----------------
        gain = 8'd52;
        in_valid = 1'b1;
        data_in = 12'sd1;
        tick();                       // edge 0: accepted into hold, zero load
        $display("accept edge %0d value 1", edge_idx);
        in_valid = 1'b0;
        data_in = '0;
        chk("imp_ready_after_accept", in_ready, 0);
        for (int e = 1; e <= 60; e++) begin
            tick();
            if (e == 14) chk("imp_ready_mid", in_ready, 0);
            if (e == 15) chk("imp_ready_slot", in_ready, 1);
            if (e == 27) chk("imp_ov_before", out_valid, 0);
            if (e == 28) chk("imp_ov_rise", out_valid, 1);
            if (e >= 28 && e <= 35) chk("imp_resp", $signed(data_out), imp_tab[e - 28]);
            if (e == 31) chk("udr_before_slot", underrun, 0);
            if (e == 32) chk("udr_at_slot", underrun, 1);
            if (e == 40) begin
                in_valid = 1'b1;
                data_in = 12'sd3;
            end
            if (e == 41) begin
                $display("accept edge %0d value 3", e);
                in_valid = 1'b0;
                data_in = '0;
                chk("udr_later_accepted", in_ready, 0);
            end
        end
        chk("udr_sticky", underrun, 1);
        chk("udr_ov_kept", out_valid, 1);

        // ---------------- Asynchronous reset mid-stream ----------------
        rst_n = 1'b0;
        #2;
        chk("mid_rst_data_out", $signed(data_out), 0);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_underrun", underrun, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        tick();
        rst_n = 1'b1;
        edge_idx = -1;

        // ---------------- DC: 100 held valid, shift 12 ----------------
        gain = 8'd40;
        in_valid = 1'b1;
        data_in = 12'sd100;
        n_acc = 0;
        chk("dc_ready_first", in_ready, 1);
        for (int e = 0; e < 240; e++) begin
            acc = in_valid && in_ready;
            if (acc) n_acc++;
            tick();
            if (e < 48) chk("dc_in_ready", in_ready, ((e + 1) % R == 0) ? 1 : 0);
            if (e == 27) chk("dc_ov_before", out_valid, 0);
            if (e == 28) chk("dc_ov_rise", out_valid, 1);
            if (e == 150 || e == 175 || e == 200 || e == 239)
                chk("dc_settled", $signed(data_out), 1600);
        end
        chk("dc_accepts", n_acc, 15);
        chk("dc_underrun", underrun, 0);

        // ---------------- Ramp through accept/load collisions ----------------
        do_reset();
        gain = 8'd40;
        in_valid = 1'b1;
        data_in = 12'sd1;
        for (int e = 0; e < 220; e++) begin
            acc = in_valid && in_ready;
            tick();
            if (e % R == 0) begin
                load_edge.push_back(e);
                load_val.push_back((pending.size() > 0) ? pending.pop_front() : 0);
            end
            if (acc) begin
                $display("accept edge %0d value %0d", e, data_in);
                pending.push_back(longint'(data_in));
                data_in = data_in + 12'sd1;
            end
            y = 0;
            foreach (load_edge[i]) begin
                int j;
                j = e - load_edge[i] - 12;
                if (j >= 0 && j < HL) y += load_val[i] * h[j];
            end
            y_sh = y >>> 12;
            exp12 = y_sh[DW-1:0];
            chk("ramp_out", $signed(data_out), exp12);
        end
        chk("ramp_underrun", underrun, 0);
        chk("ramp_out_valid", out_valid, 1);

        // ---------------- Negative full scale, shift 16 ----------------
        do_reset();
        gain = 8'd36;
        in_valid = 1'b1;
        data_in = -12'sd2048;
        for (int e = 0; e < 150; e++) begin
            tick();
            if (e == 140 || e == 149) chk("negfs_out", $signed(data_out), -2048);
        end
        chk("negfs_underrun", underrun, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
